// File: rtl/fma_pkg.sv
// Shared definitions for the FMA sequencing controller.
//   - Rounding-mode encodings (RISC-V frm style) and the dynamic selector.
//   - Exception flag bit positions within the 4-bit {NV, OF, UF, NX} vector.
//   - Default datapath latency.
//   - Helpers that resolve a requested rounding mode and classify legality.
package fma_pkg;

    localparam int unsigned DEFAULT_LATENCY = 3;

    typedef enum logic [2:0] {
        RM_RNE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100,
        RM_DYN = 3'b111
    } rm_e;

    // Flag vector layout: {invalid, overflow, underflow, inexact}
    localparam int unsigned FLAG_W  = 4;
    localparam int unsigned FLAG_NX = 0;
    localparam int unsigned FLAG_UF = 1;
    localparam int unsigned FLAG_OF = 2;
    localparam int unsigned FLAG_NV = 3;

    // A request of DYN defers to the fcsr rounding mode.
    function automatic logic [2:0] rm_resolve(input logic [2:0] req_rm,
                                              input logic [2:0] dyn_rm);
        return (req_rm == RM_DYN) ? dyn_rm : req_rm;
    endfunction

    // After resolution, 101/110/111 have no defined rounding behaviour.
    function automatic logic rm_illegal(input logic [2:0] rm);
        return (rm == 3'b101) || (rm == 3'b110) || (rm == 3'b111);
    endfunction

endpackage

// File: rtl/fma_res_fifo.sv
// Result buffer for the FMA controller.
// Ports:
//   clk_i, rst_ni  - clock, asynchronous active-low reset
//   flush_i        - empties the buffer at the next edge (dominates push/pop)
//   push_i, data_i - write side; a push while full is taken only with a pop
//   pop_i          - read side; ignored while empty
//   data_o,valid_o - head entry, stable until popped
//   count_o        - number of stored entries
module fma_res_fifo #(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign pop_ok  = pop_i && (cnt_q != '0);
    // Full-and-popping frees a slot in the same cycle, so the push is kept.
    assign push_ok = push_i && ((cnt_q != CNT_W'(DEPTH)) || pop_ok);

    always_comb begin
        wr_d  = push_ok ? ptr_inc(wr_q) : wr_q;
        rd_d  = pop_ok  ? ptr_inc(rd_q) : rd_q;
        cnt_d = cnt_q;
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok && !flush_i) begin
            mem_q[wr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_q];
    assign valid_o = (cnt_q != '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/fma_seq_ctrl.sv
// Issue/retire controller for a fixed-latency FMA datapath shared by two
// requesters.
// Ports:
//   clk_i, rst_ni          - clock, asynchronous active-low reset
//   req_valid_i/ready_o    - per-requester handshake (accept = valid & ready)
//   req_tag_i, req_rm_i    - per-requester tag and rounding mode (req 0 in LSBs)
//   dyn_rm_i               - fcsr rounding mode used when a request asks DYN
//   flush_i                - kills everything in flight and buffered
//   dp_src_sel_o           - requester whose operands load stage 0
//   stage_en_o             - per-stage datapath register enables
//   dp_rm_o                - rounding mode for the op entering stage LATENCY-1
//   dp_flags_i             - exception flags from the last stage
//   res_*                  - result handshake {id, tag, flags, illegal}
//   fflags_o, fflags_clr_i - sticky accrued flags and their clear
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and the result head stays stable
// while valid is high and ready is low.
module fma_seq_ctrl
    import fma_pkg::*;
#(
    parameter int unsigned LATENCY   = DEFAULT_LATENCY,
    parameter int unsigned TAG_W     = 4,
    parameter int unsigned RES_DEPTH = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [1:0]         req_valid_i,
    output logic [1:0]         req_ready_o,
    input  logic [2*TAG_W-1:0] req_tag_i,
    input  logic [5:0]         req_rm_i,
    input  logic [2:0]         dyn_rm_i,
    input  logic               flush_i,
    output logic               dp_src_sel_o,
    output logic [LATENCY-1:0] stage_en_o,
    output logic [2:0]         dp_rm_o,
    input  logic [FLAG_W-1:0]  dp_flags_i,
    output logic               res_valid_o,
    input  logic               res_ready_i,
    output logic               res_id_o,
    output logic [TAG_W-1:0]   res_tag_o,
    output logic [FLAG_W-1:0]  res_flags_o,
    output logic               res_illegal_o,
    output logic [FLAG_W-1:0]  fflags_o,
    input  logic               fflags_clr_i
);

    localparam int unsigned ENT_W = 1 + TAG_W + FLAG_W + 1;
    localparam int unsigned IF_W  = $clog2(LATENCY + 1);
    localparam int unsigned CNT_W = $clog2(RES_DEPTH + 1);
    localparam int unsigned OCC_W = $clog2(LATENCY + RES_DEPTH + 1) + 1;

    // Op tracking shift register, one entry per datapath stage.
    logic [LATENCY-1:0] v_q, id_q, ill_q;
    logic [TAG_W-1:0]   tag_q [LATENCY];
    logic [2:0]         rm_q  [LATENCY];

    logic [IF_W-1:0]    inflight_q, inflight_d;
    logic               last_q;
    logic [FLAG_W-1:0]  fflags_q, fflags_d;

    logic               gnt_sel, issue_ok, accept, pop, push;
    logic [TAG_W-1:0]   sel_tag;
    logic [2:0]         sel_rm, res_rm;
    logic [OCC_W-1:0]   occ;
    logic [ENT_W-1:0]   fifo_wdata, fifo_rdata;
    logic               fifo_valid;
    logic [CNT_W-1:0]   fifo_cnt;

    // Round-robin: with both requesting, favour whoever was not granted last.
    always_comb begin
        if (req_valid_i == 2'b11) gnt_sel = ~last_q;
        else                      gnt_sel = req_valid_i[1];
    end

    assign pop = fifo_valid && res_ready_i;

    // Every issued op must find a buffer slot when it retires, so count
    // in-flight ops as already occupying the buffer.
    assign occ      = OCC_W'(inflight_q) + OCC_W'(fifo_cnt) - OCC_W'(pop);
    assign issue_ok = rst_ni && !flush_i && (occ < OCC_W'(RES_DEPTH));

    assign req_ready_o  = issue_ok ? (gnt_sel ? 2'b10 : 2'b01) : 2'b00;
    assign accept       = |(req_valid_i & req_ready_o);
    assign dp_src_sel_o = rst_ni && gnt_sel;

    assign sel_tag = gnt_sel ? req_tag_i[2*TAG_W-1:TAG_W] : req_tag_i[TAG_W-1:0];
    assign sel_rm  = gnt_sel ? req_rm_i[5:3] : req_rm_i[2:0];
    assign res_rm  = rm_resolve(sel_rm, dyn_rm_i);

    always_comb begin
        stage_en_o    = '0;
        stage_en_o[0] = accept;
        for (int k = 1; k < LATENCY; k++) begin
            stage_en_o[k] = v_q[k-1];
        end
    end

    // The rounding stage works on the op about to be captured by its register.
    if (LATENCY == 1) begin : g_rm_direct
        assign dp_rm_o = accept ? res_rm : 3'b000;
    end else begin : g_rm_piped
        assign dp_rm_o = rm_q[LATENCY-2];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v_q   <= '0;
            id_q  <= '0;
            ill_q <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                tag_q[k] <= '0;
                rm_q[k]  <= '0;
            end
        end else begin
            for (int k = LATENCY - 1; k > 0; k--) begin
                v_q[k]   <= v_q[k-1] && !flush_i;
                id_q[k]  <= id_q[k-1];
                ill_q[k] <= ill_q[k-1];
                tag_q[k] <= tag_q[k-1];
                rm_q[k]  <= rm_q[k-1];
            end
            v_q[0]   <= accept;
            id_q[0]  <= gnt_sel;
            ill_q[0] <= rm_illegal(res_rm);
            tag_q[0] <= sel_tag;
            rm_q[0]  <= res_rm;
        end
    end

    always_comb begin
        case ({accept, v_q[LATENCY-1]})
            2'b10:   inflight_d = inflight_q + IF_W'(1);
            2'b01:   inflight_d = inflight_q - IF_W'(1);
            default: inflight_d = inflight_q;
        endcase
        if (flush_i) inflight_d = '0;
    end

    // Clear takes effect before the popped flags are merged in.
    always_comb begin
        fflags_d = fflags_clr_i ? '0 : fflags_q;
        if (pop && !res_illegal_o && !flush_i) begin
            fflags_d = fflags_d | res_flags_o;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight_q <= '0;
            last_q     <= 1'b1;
            fflags_q   <= '0;
        end else begin
            inflight_q <= inflight_d;
            fflags_q   <= fflags_d;
            if (accept) last_q <= gnt_sel;
        end
    end

    assign push       = v_q[LATENCY-1] && !flush_i;
    assign fifo_wdata = {id_q[LATENCY-1], tag_q[LATENCY-1], dp_flags_i, ill_q[LATENCY-1]};

    fma_res_fifo #(
        .DEPTH (RES_DEPTH),
        .WIDTH (ENT_W)
    ) u_res_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .push_i  (push),
        .data_i  (fifo_wdata),
        .pop_i   (pop),
        .data_o  (fifo_rdata),
        .valid_o (fifo_valid),
        .count_o (fifo_cnt)
    );

    assign res_valid_o   = fifo_valid;
    assign res_id_o      = fifo_valid && fifo_rdata[ENT_W-1];
    assign res_tag_o     = fifo_valid ? fifo_rdata[ENT_W-2 -: TAG_W] : '0;
    assign res_flags_o   = fifo_valid ? fifo_rdata[FLAG_W:1] : '0;
    assign res_illegal_o = fifo_valid && fifo_rdata[0];
    assign fflags_o      = fflags_q;

endmodule
